router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 101 ++++++++++
 tb/tb_router_pkt_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter feeding a router (header, buffered payload, parity, gap)
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       buf_we,
  input  logic [5:0] buf_waddr,
  input  logic [7:0] buf_wdata,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic       inject_par_err,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_in,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       req_err,
  output logic       pkt_err
);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_buf [64];
  logic [5:0]      r_len, r_idx, w_idx;
  logic [1:0]      r_dest;
  logic            r_inj;
  logic [7:0]      r_par, w_par, w_hdr, w_data;
  logic [GW-1:0]   r_gap, w_gap;
  logic            w_legal, w_valid, w_active, w_done, w_rej, w_perr;
  assign w_legal = start && (pay_len != 6'd0) && (dest_addr != 2'd3);
  // payload buffer: only writable while idle, never reset
  always_ff @(posedge clock)
    if (buf_we && r_state == IDLE) r_buf[buf_waddr] <= buf_wdata;
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic; byte states advance only on accepted bytes
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_legal) w_next = HEADER;
      HEADER:  if (!busy) w_next = PAYLOAD;
      PAYLOAD: if (!busy && r_idx == r_len - 6'd1) w_next = PARITY;
      PARITY:  if (!busy) w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (r_gap == GW'(GAP_CYCLES - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // next values of datapath and outputs, registered one cycle later
  always_comb begin
    w_hdr    = (r_state == IDLE) ? {pay_len, dest_addr} : {r_len, r_dest};
    w_idx    = (r_state == PAYLOAD) ? (busy ? r_idx : r_idx + 6'd1) : 6'd0;
    w_par    = (r_state == IDLE) ? w_hdr :
               (r_state == PAYLOAD && !busy) ? (r_par ^ r_buf[r_idx]) : r_par;
    w_gap    = (r_state == GAP) ? r_gap + GW'(1) : '0;
    w_data   = (w_next == HEADER)  ? w_hdr :
               (w_next == PAYLOAD) ? r_buf[w_idx] :
               (w_next == PARITY)  ? (w_par ^ {7'd0, r_inj}) : 8'd0;
    w_valid  = (w_next == HEADER) || (w_next == PAYLOAD);
    w_active = (w_next != IDLE);
    w_done   = (r_state == PARITY) && !busy;
    w_rej    = (r_state == IDLE) && start && !w_legal;
    w_perr   = (r_state == IDLE && w_legal) ? 1'b0 :
               pkt_err | (err && (r_state == PARITY || r_state == GAP));
  end
  // datapath and registered outputs
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_dest    <= '0;
      r_inj     <= 1'b0;
      r_par     <= '0;
      r_gap     <= '0;
      data_in   <= '0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      req_err   <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_legal) begin
        r_len  <= pay_len;
        r_dest <= dest_addr;
        r_inj  <= inject_par_err;
      end
      r_idx     <= w_idx;
      r_par     <= w_par;
      r_gap     <= w_gap;
      data_in   <= w_data;
      pkt_valid <= w_valid;
      tx_active <= w_active;
      done      <= w_done;
      req_err   <= w_rej;
      pkt_err   <= w_perr;
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized directed bench comparing the byte stream against a packet-level model
module tb_router_pkt_tx;
  localparam int GAP = 2;
  logic       clock = 0, resetn = 0, buf_we = 0, start = 0, inject_par_err = 0, busy = 0, err = 0;
  logic [5:0] buf_waddr = 0, pay_len = 0;
  logic [7:0] buf_wdata = 0;
  logic [1:0] dest_addr = 0;
  logic [7:0] data_in;
  logic       pkt_valid, tx_active, done, req_err, pkt_err;
  int         n_checks = 0, n_errs = 0;
  logic [7:0] mbuf [64];
  logic       exp_perr = 0;

  always #5 clock = ~clock;

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetn(resetn), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .start(start), .dest_addr(dest_addr), .pay_len(pay_len), .inject_par_err(inject_par_err),
    .busy(busy), .err(err), .data_in(data_in), .pkt_valid(pkt_valid), .tx_active(tx_active),
    .done(done), .req_err(req_err), .pkt_err(pkt_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, int'(data_in), 0);
    chk({tag, "_valid"}, int'(pkt_valid), 0);
    chk({tag, "_active"}, int'(tx_active), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req_err"}, int'(req_err), 0);
    chk({tag, "_pkt_err"}, int'(pkt_err), 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    buf_we = 1; buf_waddr = a; buf_wdata = d;
    tick();
    buf_we = 0;
    mbuf[a] = d;
  endtask

  // expected stream: header, payload bytes, parity; each byte stays until an edge with busy low
  task automatic send(input logic [1:0] d, input logic [5:0] l, input logic inj, input int hold_at,
                      input int hold_n, input bit rnd, input int err_mode, input bit mid, input int abort_at);
    logic [7:0] q[$];
    logic [7:0] p;
    int h, last;
    p = {l, d};
    q.push_back(p);
    for (int j = 0; j < int'(l); j++) begin
      q.push_back(mbuf[j]);
      p = p ^ mbuf[j];
    end
    q.push_back(p ^ {7'd0, inj});
    last = q.size() - 1;
    start = 1; dest_addr = d; pay_len = l; inject_par_err = inj;
    tick();
    start = 0; dest_addr = 2'($urandom); pay_len = 6'($urandom); inject_par_err = 1'($urandom);
    exp_perr = 0;
    chk("pkt_err_cleared", int'(pkt_err), 0);
    for (int i = 0; i <= last; i++) begin
      h = (i == hold_at) ? hold_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k <= h; k++) begin
        if (i == abort_at && k == 0) begin
          #2 resetn = 0;
          #1 chk_all_zero("async_reset");
          busy = 0; err = 0; buf_we = 0; start = 0;
          return;
        end
        chk("data_in", int'(data_in), int'(q[i]));
        chk("pkt_valid", int'(pkt_valid), (i < last) ? 1 : 0);
        chk("tx_active", int'(tx_active), 1);
        chk("done_low", int'(done), 0);
        chk("req_err_low", int'(req_err), 0);
        chk("pkt_err_tx", int'(pkt_err), int'(exp_perr));
        busy = (k < h);
        err = (i == last) ? (err_mode == 2) : 1'($urandom);
        buf_we = 1'($urandom); buf_waddr = 6'($urandom); buf_wdata = 8'($urandom);
        if (mid && i == int'(l) / 2 + 1 && k == 0) begin
          start = 1; dest_addr = 2'($urandom_range(0, 2)); pay_len = 6'($urandom_range(1, 63));
        end
        tick();
        start = 0;
        if (i == last && err) exp_perr = 1;
      end
    end
    busy = 0; err = 0; buf_we = 0;
    for (int g = 0; g < GAP; g++) begin
      chk("gap_done", int'(done), (g == 0) ? 1 : 0);
      chk("gap_data", int'(data_in), 0);
      chk("gap_valid", int'(pkt_valid), 0);
      chk("gap_active", int'(tx_active), 1);
      chk("gap_pkt_err", int'(pkt_err), int'(exp_perr));
      err = (err_mode == 1 && g == 0);
      if (mid && g == GAP - 1) begin
        start = 1; dest_addr = 2'd0; pay_len = 6'd5;
      end
      tick();
      start = 0;
      if (err) exp_perr = 1;
      err = 0;
    end
    chk("idle_active", int'(tx_active), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_valid", int'(pkt_valid), 0);
    chk("idle_pkt_err", int'(pkt_err), int'(exp_perr));
  endtask

  task automatic reject(input logic [1:0] d, input logic [5:0] l);
    start = 1; dest_addr = d; pay_len = l;
    tick();
    start = 0;
    chk("rej_req_err", int'(req_err), 1);
    chk("rej_active", int'(tx_active), 0);
    chk("rej_valid", int'(pkt_valid), 0);
    chk("rej_pkt_err", int'(pkt_err), int'(exp_perr));
    tick();
    chk("rej_req_err_pulse", int'(req_err), 0);
    chk("rej_active2", int'(tx_active), 0);
  endtask

  initial begin
    #1 chk_all_zero("reset");
    @(negedge clock);
    resetn = 1;
    tick();
    chk_all_zero("after_reset");
    for (int a = 0; a < 64; a++) wr(6'(a), 8'($urandom));
    wr(6'd0, 8'h11); wr(6'd1, 8'h22); wr(6'd2, 8'h33);
    // basic packet, then same with a 3-cycle stall on the 0x22 byte
    send(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1);
    send(2'd1, 6'd3, 1'b0, 2, 3, 1'b0, 0, 1'b0, -1);
    // illegal requests
    reject(2'd1, 6'd0);
    reject(2'd3, 6'd4);
    // err while idle must not set the sticky flag
    err = 1; tick(); tick(); err = 0;
    chk("idle_err_ignored", int'(pkt_err), 0);
    // corrupted parity with router error during the gap
    send(2'd1, 6'd3, 1'b1, -1, 0, 1'b0, 1, 1'b0, -1);
    for (int c = 0; c < 3; c++) begin
      err = 1'($urandom);
      tick();
      chk("pkt_err_sticky", int'(pkt_err), 1);
    end
    err = 0;
    reject(2'd3, 6'd0);
    send(2'd0, 6'd2, 1'b0, -1, 0, 1'b1, 0, 1'b0, -1);
    // asynchronous reset in the middle of the payload
    send(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, 0, 1'b0, 2);
    tick();
    chk_all_zero("held_reset");
    @(negedge clock);
    resetn = 1;
    exp_perr = 0;
    tick();
    chk_all_zero("post_reset");
    send(2'd2, 6'd3, 1'b0, -1, 0, 1'b0, 0, 1'b0, -1);
    // longest packet with a spurious start mid-packet and in the gap
    send(2'd2, 6'd63, 1'b0, -1, 0, 1'b0, 0, 1'b1, -1);
    // randomized packets
    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w < 4; w++) wr(6'($urandom), 8'($urandom));
      send(2'($urandom_range(0, 2)), (n == 0) ? 6'd1 : (n == 1) ? 6'd63 : 6'($urandom_range(1, 20)),
           1'($urandom), -1, 0, 1'b1, int'($urandom_range(0, 2)), 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
